// File: rtl/axi2mem_sp_if.sv
// AXI4 bus bundle shared by the core-side master bridge and memory-side slaves.
// Only the five channels' payload/handshake signals are carried; no clock inside.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_USER_WIDTH = 1
);
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [3:0]                aw_qos;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [3:0]                ar_qos;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi2mem_sp.sv
// AXI4 slave bridging single-beat reads/writes onto a 1-cycle-latency 64-bit SRAM.
// Bursts (len != 0) are drained or generated with SLVERR and never touch memory.
module axi2mem_sp #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_USER_WIDTH = 1,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  AXI_BUS.Slave                     slave,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]                mem_be_o,
  output logic [63:0]               mem_wdata_o,
  input  logic [63:0]               mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_RESP, RD_MEM, RD_LATCH, RD_RESP
  } state_e;

  state_e                    state_q;
  logic                      rd_prio_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic                      err_q;
  logic [63:0]               rdata_q;
  logic [7:0]                cnt_q;

  logic idle, rd_win, ar_take, aw_take, w_take, r_take, r_final;

  // Arbitration: a lone request wins; on a conflict rd_prio_q picks the channel.
  assign idle    = (state_q == IDLE);
  assign rd_win  = slave.ar_valid & (~slave.aw_valid | rd_prio_q);
  assign ar_take = idle & rd_win;
  assign aw_take = idle & slave.aw_valid & ~rd_win;
  assign w_take  = (state_q == WR_DATA) & slave.w_valid;
  assign r_take  = (state_q == RD_RESP) & slave.r_ready;
  assign r_final = ~err_q | (cnt_q == len_q);

  assign slave.ar_ready = ar_take;
  assign slave.aw_ready = aw_take;
  assign slave.w_ready  = (state_q == WR_DATA);

  assign slave.b_valid = (state_q == WR_RESP);
  assign slave.b_id    = id_q;
  assign slave.b_resp  = err_q ? 2'b10 : 2'b00;
  assign slave.b_user  = '0;

  assign slave.r_valid = (state_q == RD_RESP);
  assign slave.r_id    = id_q;
  assign slave.r_data  = err_q ? '0 : rdata_q;
  assign slave.r_resp  = err_q ? 2'b10 : 2'b00;
  assign slave.r_last  = r_final;
  assign slave.r_user  = '0;

  // Memory strobes are decoded from state so reset drops them without a clock.
  assign mem_we_o    = w_take & ~err_q;
  assign mem_req_o   = mem_we_o | (state_q == RD_MEM);
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = slave.w_strb;
  assign mem_wdata_o = slave.w_data;

  logic unused_fields;
  assign unused_fields = ^{slave.aw_size, slave.aw_burst, slave.aw_lock, slave.aw_cache,
                           slave.aw_prot, slave.aw_region, slave.aw_qos, slave.aw_user,
                           slave.ar_size, slave.ar_burst, slave.ar_lock, slave.ar_cache,
                           slave.ar_prot, slave.ar_region, slave.ar_qos, slave.ar_user,
                           slave.w_user, slave.aw_addr[2:0], slave.ar_addr[2:0],
                           slave.aw_addr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+3],
                           slave.ar_addr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_prio_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (slave.ar_valid && slave.aw_valid) rd_prio_q <= ~rd_prio_q;
          if (ar_take) begin
            id_q    <= slave.ar_id;
            addr_q  <= slave.ar_addr[MEM_ADDR_WIDTH+2:3];
            len_q   <= slave.ar_len;
            err_q   <= (slave.ar_len != 8'd0);
            cnt_q   <= '0;
            state_q <= (slave.ar_len == 8'd0) ? RD_MEM : RD_RESP;
          end else if (aw_take) begin
            id_q    <= slave.aw_id;
            addr_q  <= slave.aw_addr[MEM_ADDR_WIDTH+2:3];
            len_q   <= slave.aw_len;
            err_q   <= (slave.aw_len != 8'd0);
            state_q <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_take && (!err_q || slave.w_last)) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (slave.b_ready) state_q <= IDLE;
        end
        RD_MEM: begin
          state_q <= RD_LATCH;
        end
        RD_LATCH: begin
          rdata_q <= mem_rdata_i;
          state_q <= RD_RESP;
        end
        RD_RESP: begin
          if (r_take) begin
            cnt_q <= cnt_q + 8'd1;
            if (r_final) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2mem_sp.sv
// Randomized bench for axi2mem_sp: a behavioural SRAM plus a word-level reference memory
// and arbitration model predict every handshake, response and memory strobe.
module tb_axi2mem_sp;
  localparam int AW = 32, DW = 64, IW = 1, UW = 1, MAW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) bus ();

  logic           mem_req, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [7:0]     mem_be;
  logic [63:0]    mem_wdata, mem_rdata;

  axi2mem_sp #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
               .AXI_USER_WIDTH(UW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk(clk), .rst_n(rst_n), .slave(bus),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Behavioural single-port SRAM with 1-cycle read latency.
  logic [63:0] sram [0:1023] = '{default: 64'd0};
  int req_cnt = 0;
  always @(posedge clk) begin
    if (mem_req) begin
      req_cnt <= req_cnt + 1;
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Reference model: word memory indexed by addr[12:3] and the arbitration preference.
  logic [63:0] ref_mem [0:1023] = '{default: 64'd0};
  bit rd_prio = 1'b1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[12:3] = 10'($urandom_range(0, 15));
    return a;
  endfunction

  task automatic set_aw(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
    bus.aw_size = 3'($urandom); bus.aw_burst = 2'($urandom); bus.aw_lock = 1'($urandom);
    bus.aw_cache = 4'($urandom); bus.aw_prot = 3'($urandom); bus.aw_region = 4'($urandom);
    bus.aw_qos = 4'($urandom); bus.aw_user = 1'($urandom);
    bus.aw_valid = 1'b1;
  endtask

  task automatic set_ar(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
    bus.ar_size = 3'($urandom); bus.ar_burst = 2'($urandom); bus.ar_lock = 1'($urandom);
    bus.ar_cache = 4'($urandom); bus.ar_prot = 3'($urandom); bus.ar_region = 4'($urandom);
    bus.ar_qos = 4'($urandom); bus.ar_user = 1'($urandom);
    bus.ar_valid = 1'b1;
  endtask

  task automatic aw_phase(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    @(negedge clk);
    set_aw(id, addr, len);
    #1;
    for (int n = 0; n < 20 && !bus.aw_ready; n++) begin @(negedge clk); #1; end
    chk("aw_ready", 64'(bus.aw_ready), 64'd1);
  endtask

  task automatic ar_phase(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    @(negedge clk);
    set_ar(id, addr, len);
    #1;
    for (int n = 0; n < 20 && !bus.ar_ready; n++) begin @(negedge clk); #1; end
    chk("ar_ready", 64'(bus.ar_ready), 64'd1);
  endtask

  // Starts on the first negedge after the AW handshake edge.
  task automatic w_b_phase(input logic [IW-1:0] id, input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input logic [7:0] len, input int bstall);
    logic [9:0]  idx;
    logic [63:0] d;
    int base;
    idx = addr[12:3];
    @(negedge clk);
    bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
    base = req_cnt;
    for (int b = 0; b <= int'(len); b++) begin
      if (b > 0) @(negedge clk);
      d = (b == 0) ? data : {$urandom, $urandom};
      bus.w_data = d; bus.w_strb = strb; bus.w_last = (b == int'(len)); bus.w_valid = 1'b1;
      #1;
      chk("w_ready", 64'(bus.w_ready), 64'd1);
      chk("wr_req", 64'(mem_req), 64'(len == 8'd0));
      chk("wr_we", 64'(mem_we), 64'(len == 8'd0));
      if (len == 8'd0) begin
        chk("wr_addr", 64'(mem_addr), 64'(idx));
        chk("wr_be", 64'(mem_be), 64'(strb));
        chk("wr_wdata", mem_wdata, d);
      end
    end
    @(negedge clk);
    bus.w_valid = 1'b0;
    if (len == 8'd0)
      for (int b = 0; b < 8; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    for (int c = 0; c <= bstall; c++) begin
      if (c > 0) @(negedge clk);
      bus.b_ready = (c == bstall);
      #1;
      chk("b_valid", 64'(bus.b_valid), 64'd1);
      chk("b_resp", 64'(bus.b_resp), (len == 8'd0) ? 64'd0 : 64'd2);
      chk("b_id", 64'(bus.b_id), 64'(id));
      chk("b_user", 64'(bus.b_user), 64'd0);
      chk("b_no_req", 64'(mem_req), 64'd0);
    end
    @(negedge clk);
    bus.b_ready = 1'b0;
    #1;
    chk("b_done", 64'(bus.b_valid), 64'd0);
    chk("wr_req_count", 64'(req_cnt - base), 64'(len == 8'd0));
  endtask

  // Starts on the first negedge after the AR handshake edge (cycle T+1).
  task automatic r_phase(input logic [IW-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input int stall);
    logic [9:0] idx;
    int base;
    bit first;
    idx = addr[12:3];
    @(negedge clk);
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
    base = req_cnt;
    #1;
    if (len == 8'd0) begin
      chk("rd_req", 64'(mem_req), 64'd1);
      chk("rd_we", 64'(mem_we), 64'd0);
      chk("rd_addr", 64'(mem_addr), 64'(idx));
      chk("r_early1", 64'(bus.r_valid), 64'd0);
      @(negedge clk); #1;
      chk("rd_req_once", 64'(mem_req), 64'd0);
      chk("r_early2", 64'(bus.r_valid), 64'd0);
      @(negedge clk);
    end
    first = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      for (int c = 0; c <= stall; c++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        bus.r_ready = (c == stall);
        #1;
        chk("r_valid", 64'(bus.r_valid), 64'd1);
        chk("r_data", bus.r_data, (len == 8'd0) ? ref_mem[idx] : 64'd0);
        chk("r_resp", 64'(bus.r_resp), (len == 8'd0) ? 64'd0 : 64'd2);
        chk("r_last", 64'(bus.r_last), 64'(b == int'(len)));
        chk("r_id", 64'(bus.r_id), 64'(id));
        chk("r_no_req", 64'(mem_req), 64'd0);
      end
    end
    @(negedge clk);
    bus.r_ready = 1'b0;
    #1;
    chk("r_done", 64'(bus.r_valid), 64'd0);
    chk("rd_req_count", 64'(req_cnt - base), 64'(len == 8'd0));
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input logic [7:0] len, input int bstall);
    aw_phase(id, addr, len);
    w_b_phase(id, addr, data, strb, len, bstall);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input int stall);
    ar_phase(id, addr, len);
    r_phase(id, addr, len, stall);
  endtask

  // Both channels request in the same cycle; the loser is re-presented afterwards.
  task automatic conflict(input logic [IW-1:0] idw, input logic [31:0] aw_a, input logic [63:0] data,
                          input logic [IW-1:0] idr, input logic [31:0] ar_a);
    bit exp_rd;
    exp_rd = rd_prio;
    @(negedge clk);
    set_aw(idw, aw_a, 8'd0);
    set_ar(idr, ar_a, 8'd0);
    #1;
    chk("arb_ar_ready", 64'(bus.ar_ready), 64'(exp_rd));
    chk("arb_aw_ready", 64'(bus.aw_ready), 64'(!exp_rd));
    rd_prio = !rd_prio;
    if (exp_rd) begin
      r_phase(idr, ar_a, 8'd0, 0);
      do_write(idw, aw_a, data, 8'hFF, 8'd0, 0);
    end else begin
      w_b_phase(idw, aw_a, data, 8'hFF, 8'd0, 0);
      do_read(idr, ar_a, 8'd0, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int kind;
    logic [31:0] a;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
    bus.ar_valid = 1'b0; bus.r_ready = 1'b0;
    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
    bus.aw_lock = 1'b0; bus.aw_cache = '0; bus.aw_prot = '0; bus.aw_region = '0;
    bus.aw_qos = '0; bus.aw_user = '0;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
    bus.ar_lock = 1'b0; bus.ar_cache = '0; bus.ar_prot = '0; bus.ar_region = '0;
    bus.ar_qos = '0; bus.ar_user = '0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_user = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
    chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
    chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    #1 rst_n = 1'b1;

    // Two back-to-back conflicts: read first, then write.
    conflict(1'b1, 32'h0000_0040, 64'hDEAD_BEEF_0123_4567, 1'b0, 32'h0000_0048);
    conflict(1'b0, 32'h0000_0050, 64'h0F0F_F0F0_1234_5678, 1'b1, 32'h0000_0040);

    do_write(1'b0, 32'h0000_0018, 64'h1122_3344_5566_7788, 8'hFF, 8'd0, 0);
    do_read(1'b1, 32'h0000_0018, 8'd0, 0);
    do_write(1'b1, 32'h0000_0100, 64'hAAAA_AAAA_BBBB_BBBB, 8'hF0, 8'd0, 0);
    do_read(1'b0, 32'h0000_0100, 8'd0, 0);
    do_read(1'b1, 32'h0000_0018, 8'd0, 5);
    do_write(1'b1, 32'hFFFF_E058, 64'h0102_0304_0506_0708, 8'h3C, 8'd0, 4);
    do_read(1'b0, 32'h0000_0058, 8'd0, 0);
    do_read(1'b1, 32'h0000_0018, 8'd3, 0);
    do_write(1'b0, 32'h0000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd1, 0);
    do_read(1'b0, 32'h0000_0018, 8'd0, 0);

    // Reset pulse while a read response is waiting for r_ready.
    ar_phase(1'b1, 32'h0000_0018, 8'd0);
    @(negedge clk); bus.ar_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rstmid_r_valid_before", 64'(bus.r_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_r_valid_async", 64'(bus.r_valid), 64'd0);
    chk("rstmid_mem_req", 64'(mem_req), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    rd_prio = 1'b1;
    @(negedge clk); #1;
    chk("rstmid_no_r", 64'(bus.r_valid), 64'd0);
    chk("rstmid_no_b", 64'(bus.b_valid), 64'd0);
    do_read(1'b0, 32'h0000_0018, 8'd0, 1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      a = rnd_addr();
      case (kind)
        0: do_write(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), 8'd0, $urandom_range(0, 3));
        1: do_read(1'($urandom), a, 8'd0, $urandom_range(0, 3));
        2: do_write(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), 8'($urandom_range(1, 3)),
                    $urandom_range(0, 2));
        3: do_read(1'($urandom), a, 8'($urandom_range(1, 4)), $urandom_range(0, 1));
        default: conflict(1'($urandom), a, {$urandom, $urandom}, 1'($urandom), rnd_addr());
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
